// File: rtl/sequenciador_movimentos.sv
// -----------------------------------------------------------------------------
// sequenciador_movimentos
//
// Control unit for the servo datapath. Buffers 3-bit cube moves coming from
// the solver side in a small FIFO and executes them one at a time. For each
// move it clears/enables the base, lid (tampa) and flipper (peteleco) settle
// counters, writes the base position register, toggles the lid and drives
// the flipper position, waiting for each counter's terminal (fim) in turn.
//
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   cmd_valid/cmd_move      move offered by the solver side
//   cmd_ready               FIFO can accept a move (not full)
//   cancela                 flush queued moves; the move in progress finishes
//   move                    registered current move, to the datapath
//   move_servo_*            datapath decode of move: which servos it uses
//   fim_servo_*             settle counter terminals
//   zera_servo_*            settle counter clears
//   conta_servo_*           settle counter enables
//   we_registrador          load base position register from move
//   shifta_servo_tampa      one-cycle lid toggle
//   gira                    flipper position (1 = flip)
//   ocupado                 sequencer not idle
//   feito                   one-cycle pulse per completed move
//   fila_vazia/fila_cheia   FIFO empty / full
//   nivel                   FIFO occupancy
// -----------------------------------------------------------------------------
module sequenciador_movimentos #(
  parameter int PROFUNDIDADE = 8,
  parameter int LOG2_PROF    = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd_move,
  output logic                 cmd_ready,
  input  logic                 cancela,
  output logic [2:0]           move,
  input  logic                 move_servo_base,
  input  logic                 move_servo_tampa,
  input  logic                 move_servo_peteleco,
  input  logic                 fim_servo_base,
  input  logic                 fim_servo_tampa,
  input  logic                 fim_servo_peteleco,
  output logic                 zera_servo_base,
  output logic                 zera_servo_tampa,
  output logic                 zera_servo_peteleco,
  output logic                 conta_servo_base,
  output logic                 conta_servo_tampa,
  output logic                 conta_servo_peteleco,
  output logic                 we_registrador,
  output logic                 shifta_servo_tampa,
  output logic                 gira,
  output logic                 ocupado,
  output logic                 feito,
  output logic                 fila_vazia,
  output logic                 fila_cheia,
  output logic [LOG2_PROF:0]   nivel
);

  localparam int NIVEL_W = LOG2_PROF + 1;
  localparam logic [LOG2_PROF:0] NIVEL_MAX = NIVEL_W'(PROFUNDIDADE);

  typedef enum logic [3:0] {
    IDLE, CARREGA, BASE_INI, BASE_ESP, TAMPA_INI, TAMPA_ESP,
    PET_IDA_INI, PET_IDA_ESP, PET_VOLTA_INI, PET_VOLTA_ESP, FIM
  } estado_t;

  // Output bundle bit order:
  // [10] zera_base [9] zera_tampa [8] zera_peteleco
  // [7] conta_base [6] conta_tampa [5] conta_peteleco
  // [4] we_registrador [3] shifta_tampa [2] gira [1] ocupado [0] feito
  function automatic logic [10:0] saidas_f(input estado_t e);
    logic [10:0] s;
    s = 11'b000_000_000_00;
    case (e)
      IDLE:          s = 11'b111_000_000_00;
      CARREGA:       s = 11'b000_000_000_10;
      BASE_INI:      s = 11'b100_000_100_10;
      BASE_ESP:      s = 11'b000_100_000_10;
      TAMPA_INI:     s = 11'b010_000_010_10;
      TAMPA_ESP:     s = 11'b000_010_000_10;
      PET_IDA_INI:   s = 11'b001_000_001_10;
      PET_IDA_ESP:   s = 11'b000_001_001_10;
      PET_VOLTA_INI: s = 11'b001_000_000_10;
      PET_VOLTA_ESP: s = 11'b000_001_000_10;
      FIM:           s = 11'b000_000_000_11;
      default:       s = 11'b111_000_000_00;
    endcase
    return s;
  endfunction

  estado_t              estado_q, estado_d;
  logic [2:0]           flags_q, flags_d;     // {base, tampa, peteleco}
  logic [2:0]           move_q, move_d;
  logic [10:0]          saidas_q;
  logic [2:0]           mem_q [PROFUNDIDADE];
  logic [LOG2_PROF-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_PROF-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG2_PROF:0]   nivel_q, nivel_d;
  logic                 push_s, pop_s, vazia_s, cheia_s;

  assign vazia_s = (nivel_q == {NIVEL_W{1'b0}});
  assign cheia_s = (nivel_q == NIVEL_MAX);

  // A push is refused when full (even with a simultaneous pop) and is
  // dropped during a flush; a flush also suppresses the pop so the FSM never
  // starts a move that was being cancelled.
  assign push_s = cmd_valid & ~cheia_s & ~cancela;
  assign pop_s  = ((estado_q == IDLE) | (estado_q == FIM)) & ~vazia_s & ~cancela;

  // FIFO pointer/level and current-move next-state logic
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    nivel_d  = nivel_q;
    move_d   = move_q;
    if (cancela) begin
      wr_ptr_d = {LOG2_PROF{1'b0}};
      rd_ptr_d = {LOG2_PROF{1'b0}};
      nivel_d  = {NIVEL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + {{(LOG2_PROF-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + {{(LOG2_PROF-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      nivel_d = nivel_q + NIVEL_W'(push_s) - NIVEL_W'(pop_s);
    end
    if (pop_s) begin
      move_d = mem_q[rd_ptr_q];
    end else begin
      move_d = move_q;
    end
  end

  // Sequencer next-state logic; servo flags are captured only in CARREGA
  always_comb begin
    estado_d = estado_q;
    flags_d  = flags_q;
    case (estado_q)
      IDLE: begin
        if (pop_s) estado_d = CARREGA;
        else       estado_d = IDLE;
      end
      CARREGA: begin
        flags_d = {move_servo_base, move_servo_tampa, move_servo_peteleco};
        if (move_servo_base)          estado_d = BASE_INI;
        else if (move_servo_tampa)    estado_d = TAMPA_INI;
        else if (move_servo_peteleco) estado_d = PET_IDA_INI;
        else                          estado_d = FIM;
      end
      BASE_INI: estado_d = BASE_ESP;
      BASE_ESP: begin
        if (!fim_servo_base) estado_d = BASE_ESP;
        else if (flags_q[1]) estado_d = TAMPA_INI;
        else if (flags_q[0]) estado_d = PET_IDA_INI;
        else                 estado_d = FIM;
      end
      TAMPA_INI: estado_d = TAMPA_ESP;
      TAMPA_ESP: begin
        if (!fim_servo_tampa) estado_d = TAMPA_ESP;
        else if (flags_q[0])  estado_d = PET_IDA_INI;
        else                  estado_d = FIM;
      end
      PET_IDA_INI: estado_d = PET_IDA_ESP;
      PET_IDA_ESP: begin
        if (fim_servo_peteleco) estado_d = PET_VOLTA_INI;
        else                    estado_d = PET_IDA_ESP;
      end
      PET_VOLTA_INI: estado_d = PET_VOLTA_ESP;
      PET_VOLTA_ESP: begin
        if (fim_servo_peteleco) estado_d = FIM;
        else                    estado_d = PET_VOLTA_ESP;
      end
      FIM: begin
        // Back-to-back moves skip IDLE
        if (pop_s) estado_d = CARREGA;
        else       estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  // FIFO storage; data words need no reset since occupancy guards them
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= cmd_move;
    end
  end

  // State, pointers and registered outputs. Outputs are decoded from the
  // next state so they line up cycle-for-cycle with estado_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= IDLE;
      flags_q  <= 3'b000;
      move_q   <= 3'b000;
      wr_ptr_q <= {LOG2_PROF{1'b0}};
      rd_ptr_q <= {LOG2_PROF{1'b0}};
      nivel_q  <= {NIVEL_W{1'b0}};
      saidas_q <= saidas_f(IDLE);
    end else begin
      estado_q <= estado_d;
      flags_q  <= flags_d;
      move_q   <= move_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      nivel_q  <= nivel_d;
      saidas_q <= saidas_f(estado_d);
    end
  end

  assign move                 = move_q;
  assign zera_servo_base      = saidas_q[10];
  assign zera_servo_tampa     = saidas_q[9];
  assign zera_servo_peteleco  = saidas_q[8];
  assign conta_servo_base     = saidas_q[7];
  assign conta_servo_tampa    = saidas_q[6];
  assign conta_servo_peteleco = saidas_q[5];
  assign we_registrador       = saidas_q[4];
  assign shifta_servo_tampa   = saidas_q[3];
  assign gira                 = saidas_q[2];
  assign ocupado              = saidas_q[1];
  assign feito                = saidas_q[0];
  assign fila_vazia           = vazia_s;
  assign fila_cheia           = cheia_s;
  assign cmd_ready            = ~cheia_s;
  assign nivel                = nivel_q;

endmodule

// File: tb/tb_sequenciador_movimentos.sv
// -----------------------------------------------------------------------------
// Self-checking bench for sequenciador_movimentos. A transaction-level model
// keeps the queued moves and, when a move starts, lays out the expected
// per-cycle output pattern for the whole move (CARREGA, per-servo INI plus
// settle cycles, FIM). A small servo environment raises each fim after a
// per-move number of counting cycles and drives noise elsewhere.
// -----------------------------------------------------------------------------
module tb_sequenciador_movimentos;

  localparam int PROF = 8;
  localparam int LOG2 = 3;

  // Expected output patterns, bit order
  // {zb,zt,zp, cb,ct,cp, we,sh,gi, oc,fe}
  localparam logic [10:0] V_IDLE = 11'b111_000_000_00;
  localparam logic [10:0] V_CAR  = 11'b000_000_000_10;
  localparam logic [10:0] V_BINI = 11'b100_000_100_10;
  localparam logic [10:0] V_BESP = 11'b000_100_000_10;
  localparam logic [10:0] V_TINI = 11'b010_000_010_10;
  localparam logic [10:0] V_TESP = 11'b000_010_000_10;
  localparam logic [10:0] V_PII  = 11'b001_000_001_10;
  localparam logic [10:0] V_PIE  = 11'b000_001_001_10;
  localparam logic [10:0] V_PVI  = 11'b001_000_000_10;
  localparam logic [10:0] V_PVE  = 11'b000_001_000_10;
  localparam logic [10:0] V_FIM  = 11'b000_000_000_11;

  typedef struct {
    logic [2:0] code;
    int         db;
    int         dt;
    int         dp;
  } mv_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset, cmd_valid, cmd_ready, cancela;
  logic [2:0]      cmd_move, move;
  logic            move_servo_base, move_servo_tampa, move_servo_peteleco;
  logic            fim_servo_base, fim_servo_tampa, fim_servo_peteleco;
  logic            zera_servo_base, zera_servo_tampa, zera_servo_peteleco;
  logic            conta_servo_base, conta_servo_tampa, conta_servo_peteleco;
  logic            we_registrador, shifta_servo_tampa, gira, ocupado, feito;
  logic            fila_vazia, fila_cheia;
  logic [LOG2:0]   nivel;

  sequenciador_movimentos #(.PROFUNDIDADE(PROF), .LOG2_PROF(LOG2)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_move(cmd_move), .cmd_ready(cmd_ready),
    .cancela(cancela), .move(move),
    .move_servo_base(move_servo_base), .move_servo_tampa(move_servo_tampa),
    .move_servo_peteleco(move_servo_peteleco),
    .fim_servo_base(fim_servo_base), .fim_servo_tampa(fim_servo_tampa),
    .fim_servo_peteleco(fim_servo_peteleco),
    .zera_servo_base(zera_servo_base), .zera_servo_tampa(zera_servo_tampa),
    .zera_servo_peteleco(zera_servo_peteleco),
    .conta_servo_base(conta_servo_base), .conta_servo_tampa(conta_servo_tampa),
    .conta_servo_peteleco(conta_servo_peteleco),
    .we_registrador(we_registrador), .shifta_servo_tampa(shifta_servo_tampa),
    .gira(gira), .ocupado(ocupado), .feito(feito),
    .fila_vazia(fila_vazia), .fila_cheia(fila_cheia), .nivel(nivel)
  );

  int          checks = 0;
  int          errors = 0;
  mv_t         fifo_m[$];
  logic [10:0] exp_q[$];
  mv_t         cur;
  logic [2:0]  tab [8];
  int          cnt_b, cnt_t, cnt_p;
  logic        saw_full, tampa_rst_done, saw_cancel_busy;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Lay out the per-cycle outputs of a move that starts on the next cycle
  task automatic monta(input mv_t m);
    logic [2:0] f;
    f = tab[m.code];
    exp_q.push_back(V_CAR);
    if (f[2]) begin
      exp_q.push_back(V_BINI);
      for (int i = 0; i < m.db; i++) exp_q.push_back(V_BESP);
    end
    if (f[1]) begin
      exp_q.push_back(V_TINI);
      for (int i = 0; i < m.dt; i++) exp_q.push_back(V_TESP);
    end
    if (f[0]) begin
      exp_q.push_back(V_PII);
      for (int i = 0; i < m.dp; i++) exp_q.push_back(V_PIE);
      exp_q.push_back(V_PVI);
      for (int i = 0; i < m.dp; i++) exp_q.push_back(V_PVE);
    end
    exp_q.push_back(V_FIM);
  endtask

  initial begin
    logic [10:0] exp_v, obs_v;
    logic [2:0]  key, fl;
    logic        do_reset, canc, vld, pop, accept;
    int          phase, dmin, dmax;
    mv_t         nm;

    key = 3'($urandom_range(0, 7));
    for (int i = 0; i < 8; i++) tab[i] = 3'(i) ^ key;   // every flag combination occurs

    reset = 1'b1; cmd_valid = 1'b0; cmd_move = 3'b000; cancela = 1'b0;
    move_servo_base = 1'b0; move_servo_tampa = 1'b0; move_servo_peteleco = 1'b0;
    fim_servo_base = 1'b0; fim_servo_tampa = 1'b0; fim_servo_peteleco = 1'b0;
    cur = '{3'b000, 1, 1, 1};
    cnt_b = 0; cnt_t = 0; cnt_p = 0;
    saw_full = 1'b0; tampa_rst_done = 1'b0; saw_cancel_busy = 1'b0;
    repeat (2) @(negedge clock);

    for (int cyc = 0; cyc < 4500; cyc++) begin
      @(negedge clock);
      exp_v = (exp_q.size() == 0) ? V_IDLE : exp_q[0];

      obs_v = {zera_servo_base, zera_servo_tampa, zera_servo_peteleco,
               conta_servo_base, conta_servo_tampa, conta_servo_peteleco,
               we_registrador, shifta_servo_tampa, gira, ocupado, feito};
      verifica("saidas", 32'(obs_v), 32'(exp_v));
      verifica("move", 32'(move), 32'(cur.code));
      verifica("nivel", 32'(nivel), 32'(fifo_m.size()));
      verifica("fila_vazia", 32'(fila_vazia), 32'(fifo_m.size() == 0));
      verifica("fila_cheia", 32'(fila_cheia), 32'(fifo_m.size() == PROF));
      verifica("cmd_ready", 32'(cmd_ready), 32'(fifo_m.size() != PROF));

      // Phase 1: short settles; phase 2: long settles, heavy pushes, no
      // flush/reset (fills the FIFO); phase 3: short settles again
      phase = (cyc < 1500) ? 1 : ((cyc < 3000) ? 2 : 3);
      dmin  = (phase == 2) ? 10 : 1;
      dmax  = (phase == 2) ? 20 : ((phase == 1) ? 4 : 3);

      do_reset = 1'b0;
      if (phase != 2 && !tampa_rst_done && cyc > 300 && exp_v == V_TESP) do_reset = 1'b1;
      else if (phase != 2 && $urandom_range(0, 499) == 0) do_reset = 1'b1;

      canc = !do_reset && phase != 2 && exp_q.size() > 0 && exp_v != V_FIM &&
             $urandom_range(0, 39) == 0;
      vld  = (phase == 2) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);

      // Flags follow the current move only while CARREGA samples them
      if (exp_v == V_CAR) fl = tab[cur.code];
      else                fl = 3'($urandom_range(0, 7));

      if (exp_v[10]) cnt_b = 0;
      if (exp_v[9])  cnt_t = 0;
      if (exp_v[8])  cnt_p = 0;
      if (exp_v[7]) begin fim_servo_base = (cnt_b + 1 >= cur.db); cnt_b++; end
      else          fim_servo_base = 1'($urandom_range(0, 1));
      if (exp_v[6]) begin fim_servo_tampa = (cnt_t + 1 >= cur.dt); cnt_t++; end
      else          fim_servo_tampa = 1'($urandom_range(0, 1));
      if (exp_v[5]) begin fim_servo_peteleco = (cnt_p + 1 >= cur.dp); cnt_p++; end
      else          fim_servo_peteleco = 1'($urandom_range(0, 1));

      nm.code = 3'($urandom_range(0, 7));
      nm.db   = $urandom_range(dmin, dmax);
      nm.dt   = $urandom_range(dmin, dmax);
      nm.dp   = $urandom_range(dmin, dmax);

      reset = do_reset; cancela = canc; cmd_valid = vld; cmd_move = nm.code;
      {move_servo_base, move_servo_tampa, move_servo_peteleco} = fl;

      // Model update for the coming edge
      if (do_reset) begin
        if (exp_v == V_TESP) tampa_rst_done = 1'b1;
        fifo_m.delete(); exp_q.delete();
        cur = '{3'b000, 1, 1, 1};
      end else begin
        pop    = (exp_q.size() == 0 || exp_v == V_FIM) && fifo_m.size() > 0 && !canc;
        accept = vld && fifo_m.size() < PROF && !canc;
        if (vld && fifo_m.size() == PROF) saw_full = 1'b1;
        if (canc && fifo_m.size() > 0) saw_cancel_busy = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (pop) begin
          cur = fifo_m.pop_front();
          monta(cur);
        end
        if (canc)        fifo_m.delete();
        else if (accept) fifo_m.push_back(nm);
      end
    end

    verifica("cover_full_refused", 32'(saw_full), 32'd1);
    verifica("cover_reset_tampa_esp", 32'(tampa_rst_done), 32'd1);
    verifica("cover_cancel_with_queue", 32'(saw_cancel_busy), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequenciador_movimentos.md
Name: sequenciador_movimentos

Overview:
- Control unit for the servo datapath: base, lid (tampa) and flipper (peteleco) servos, each with its own settle-time counter.
- Buffers a queue of 3-bit cube moves from the solver side and executes them one at a time.
- For each move it drives the datapath's counter zero/count strobes, the base register write, the lid toggle and the flipper position, then waits for each settle counter's fim.
- Sits between the solution-stream logic and the servo datapath.

Parameters:
PROFUNDIDADE, 8, move FIFO depth; power of two, at least 2.
LOG2_PROF, 3, log2(PROFUNDIDADE).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  move offered
cmd_move  in  3  move code
cmd_ready  out  1  FIFO can accept (= !fila_cheia)
cancela  in  1  flush queued (not in-progress) moves
move  out  3  registered current move, to datapath
move_servo_base  in  1  datapath decode: move uses base
move_servo_tampa  in  1  datapath decode: move uses lid
move_servo_peteleco  in  1  datapath decode: move uses flipper
fim_servo_base  in  1  base settle counter terminal
fim_servo_tampa  in  1  lid settle counter terminal
fim_servo_peteleco  in  1  flipper settle counter terminal
zera_servo_base  out  1  clear base counter
zera_servo_tampa  out  1  clear lid counter
zera_servo_peteleco  out  1  clear flipper counter
conta_servo_base  out  1  enable base counter
conta_servo_tampa  out  1  enable lid counter
conta_servo_peteleco  out  1  enable flipper counter
we_registrador  out  1  load base position register from move
shifta_servo_tampa  out  1  one-cycle lid toggle
gira  out  1  flipper position (1 = flip)
ocupado  out  1  state != IDLE
feito  out  1  one-cycle pulse per completed move
fila_vazia  out  1  FIFO empty
fila_cheia  out  1  FIFO full
nivel  out  LOG2_PROF+1  FIFO occupancy

Behaviour:
- Reset (sync) forces the following:
  - State IDLE, FIFO empty, nivel=0, move=000, gira=0.
  - zera_*=1, conta_*=0, we_registrador=0, shifta_servo_tampa=0, feito=0.
  - cmd_ready=1.
- Reset mid-move is immediate; the lid flip-flop and base register are reset by the datapath on the same reset.
- FIFO push: cmd_valid && cmd_ready.
  - When full, push is refused even if a pop occurs the same cycle.
  - A push into an empty FIFO is seen by IDLE one cycle later (no bypass).
  - Pointers wrap modulo PROFUNDIDADE.
- cancela empties the FIFO next edge and leaves the current move running.
  - A push in the same cycle as cancela is dropped.
- Outputs per state: unlisted outputs are 0; zera_* are 1 only where stated.
  - IDLE: zera_* all 1. If !fila_vazia, pop the head into move and go to CARREGA.
  - CARREGA: sample move_servo_*. Go to the first set flag in the order BASE_INI, TAMPA_INI, PET_IDA_INI. If no flag is set, go to FIM.
  - BASE_INI: we_registrador=1, zera_servo_base=1 (one cycle). Go to BASE_ESP.
  - BASE_ESP: conta_servo_base=1 until fim_servo_base=1. Then go to the next flagged servo (tampa, then peteleco) or FIM.
  - TAMPA_INI: shifta_servo_tampa=1, zera_servo_tampa=1 (exactly one cycle). Go to TAMPA_ESP.
  - TAMPA_ESP: conta_servo_tampa=1 until fim_servo_tampa. Then go to PET_IDA_INI if flagged, else FIM.
  - PET_IDA_INI: gira=1, zera_servo_peteleco=1.
  - PET_IDA_ESP: gira=1, conta_servo_peteleco=1 until fim_servo_peteleco.
  - PET_VOLTA_INI: gira=0, zera_servo_peteleco=1.
  - PET_VOLTA_ESP: gira=0, conta_servo_peteleco=1 until fim_servo_peteleco. Then go to FIM.
  - FIM: feito=1 for one cycle. Go to CARREGA with a pop if the FIFO is non-empty, else IDLE.
- Move flags are latched in CARREGA; later changes to move_servo_* are ignored until the next CARREGA.
- move is held constant from the pop until the next pop.
- fim inputs are ignored outside their own ESP state.
- A fim already high on entry to ESP exits after one ESP cycle.
- Latency from push into empty idle FIFO to first INI state is 3 cycles: IDLE sees data, then CARREGA, then INI.
- Back-to-back moves: FIM to CARREGA with no IDLE gap.

Test Plan:
- Reset with all inputs 0 -> zera_*=1, move=000, cmd_ready=1, nivel=0, ocupado=0.
- Push one base-only move (base flag=1, fim_servo_base high after 5 ESP cycles) -> we_registrador is one pulse. Then conta_servo_base=1 for 5 cycles, then feito pulse, then IDLE.
- Push one move with lid and flipper flags set, fim pulses after 3 cycles each -> shifta_servo_tampa one pulse. Then tampa count, then gira=1 for the outbound phase, gira=0 for return, then a single feito.
- Push 9 moves with PROFUNDIDADE=8 while the FSM is stalled (fim held 0) -> the 9th push is refused, fila_cheia=1, nivel=8. Releasing fim drains the FIFO in order; move sequence equals pushed order, including wrap.
- Move with no flags -> CARREGA then FIM; feito 2 cycles after pop, no servo strobes.
- cancela during PET_IDA_ESP with 3 queued -> nivel=0 next cycle; the current flip completes with one feito, then IDLE.
- reset asserted in TAMPA_ESP -> next cycle IDLE, FIFO empty, all outputs at reset values.
